// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX pipeline register: ALU command encodings
// and operand forwarding-source selects.
package id_ex_stage_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_XOR  = 3'd2,
    ALU_SLT  = 3'd3,
    ALU_AND  = 3'd4,
    ALU_NAND = 3'd5,
    ALU_NOR  = 3'd6,
    ALU_OR   = 3'd7
  } alu_cmd_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

endpackage

// File: rtl/id_ex_stage_fwd_select.sv
// Operand bypass mux: picks the youngest in-flight writer of a source register,
// falling back to register-file data. Register 0 is never bypassed.
module fwd_select
  import id_ex_stage_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     reg_data,
  input  logic                  exmem_we,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]     exmem_data,
  input  logic                  memwb_we,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]     memwb_data,
  output logic [DATA_W-1:0]     data,
  output logic [1:0]            sel
);

  logic addr_nonzero;

  assign addr_nonzero = (addr != '0);

  always_comb begin
    data = reg_data;
    sel  = FWD_REG;
    // EX/MEM holds the newer result, so it outranks MEM/WB
    if (exmem_we && (exmem_rd == addr) && addr_nonzero) begin
      data = exmem_data;
      sel  = FWD_EXMEM;
    end else if (memwb_we && (memwb_rd == addr) && addr_nonzero) begin
      data = memwb_data;
      sel  = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, flush/stall control and a
// saturating stall-cycle counter. All outputs come straight from flops.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [4:0]             rs_addr,
  input  logic [4:0]             rt_addr,
  input  logic [4:0]             rd_addr,
  input  logic [31:0]            rs_data,
  input  logic [31:0]            rt_data,
  input  logic [15:0]            imm,
  input  logic                   imm_sext,
  input  logic                   alu_src,
  input  logic [2:0]             alu_cmd,
  input  logic                   reg_we,
  input  logic                   exmem_we,
  input  logic [4:0]             exmem_rd,
  input  logic [31:0]            exmem_data,
  input  logic                   memwb_we,
  input  logic [4:0]             memwb_rd,
  input  logic [31:0]            memwb_data,
  output logic                   ex_valid,
  output logic [31:0]            operandA,
  output logic [31:0]            operandB,
  output logic [2:0]             command,
  output logic [4:0]             ex_rd,
  output logic                   ex_reg_we,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  logic                   ex_valid_q,  ex_valid_d;
  logic [31:0]            operand_a_q, operand_a_d;
  logic [31:0]            operand_b_q, operand_b_d;
  logic [2:0]             command_q,   command_d;
  logic [4:0]             ex_rd_q,     ex_rd_d;
  logic                   ex_reg_we_q, ex_reg_we_d;
  logic [1:0]             fwd_a_q,     fwd_a_d;
  logic [1:0]             fwd_b_q,     fwd_b_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [31:0] rs_fwd_data, rt_fwd_data;
  logic [1:0]  rs_fwd_sel,  rt_fwd_sel;
  logic [31:0] imm_ext;

  fwd_select u_fwd_a (
    .addr       (rs_addr),
    .reg_data   (rs_data),
    .exmem_we   (exmem_we),
    .exmem_rd   (exmem_rd),
    .exmem_data (exmem_data),
    .memwb_we   (memwb_we),
    .memwb_rd   (memwb_rd),
    .memwb_data (memwb_data),
    .data       (rs_fwd_data),
    .sel        (rs_fwd_sel)
  );

  fwd_select u_fwd_b (
    .addr       (rt_addr),
    .reg_data   (rt_data),
    .exmem_we   (exmem_we),
    .exmem_rd   (exmem_rd),
    .exmem_data (exmem_data),
    .memwb_we   (memwb_we),
    .memwb_rd   (memwb_rd),
    .memwb_data (memwb_data),
    .data       (rt_fwd_data),
    .sel        (rt_fwd_sel)
  );

  assign imm_ext = {{16{imm[15] & imm_sext}}, imm};

  always_comb begin
    ex_valid_d  = ex_valid_q;
    operand_a_d = operand_a_q;
    operand_b_d = operand_b_q;
    command_d   = command_q;
    ex_rd_d     = ex_rd_q;
    ex_reg_we_d = ex_reg_we_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      // Squash turns the slot into a bubble; operand registers keep their value
      ex_valid_d  = 1'b0;
      ex_reg_we_d = 1'b0;
      command_d   = ALU_ADD;
    end else if (stall) begin
      if (stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
    end else begin
      ex_valid_d  = in_valid;
      ex_reg_we_d = reg_we & in_valid;
      ex_rd_d     = rd_addr;
      command_d   = alu_cmd;
      operand_a_d = rs_fwd_data;
      fwd_a_d     = rs_fwd_sel;
      if (alu_src) begin
        operand_b_d = imm_ext;
        fwd_b_d     = FWD_REG;
      end else begin
        operand_b_d = rt_fwd_data;
        fwd_b_d     = rt_fwd_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      operand_a_q <= '0;
      operand_b_q <= '0;
      command_q   <= ALU_ADD;
      ex_rd_q     <= '0;
      ex_reg_we_q <= 1'b0;
      fwd_a_q     <= FWD_REG;
      fwd_b_q     <= FWD_REG;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      operand_a_q <= operand_a_d;
      operand_b_q <= operand_b_d;
      command_q   <= command_d;
      ex_rd_q     <= ex_rd_d;
      ex_reg_we_q <= ex_reg_we_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign operandA     = operand_a_q;
  assign operandB     = operand_b_q;
  assign command      = command_q;
  assign ex_rd        = ex_rd_q;
  assign ex_reg_we    = ex_reg_we_q;
  assign fwd_a        = fwd_a_q;
  assign fwd_b        = fwd_b_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding, immediates, stall/flush priority,
// asynchronous reset and counter saturation (counter narrowed to 3 bits).
module tb_id_ex_stage;

  localparam int unsigned SCW = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, stall, flush;
  logic [4:0]     rs_addr, rt_addr, rd_addr;
  logic [31:0]    rs_data, rt_data;
  logic [15:0]    imm;
  logic           imm_sext, alu_src;
  logic [2:0]     alu_cmd;
  logic           reg_we;
  logic           exmem_we;
  logic [4:0]     exmem_rd;
  logic [31:0]    exmem_data;
  logic           memwb_we;
  logic [4:0]     memwb_rd;
  logic [31:0]    memwb_data;
  logic           ex_valid;
  logic [31:0]    operandA, operandB;
  logic [2:0]     command;
  logic [4:0]     ex_rd;
  logic           ex_reg_we;
  logic [1:0]     fwd_a, fwd_b;
  logic [SCW-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.STALL_CNT_W(SCW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .imm_sext(imm_sext),
    .alu_src(alu_src), .alu_cmd(alu_cmd), .reg_we(reg_we),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .ex_valid(ex_valid), .operandA(operandA), .operandB(operandB),
    .command(command), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One full cycle: inputs set after a falling edge are captured on the rising
  // edge and the outputs are sampled on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; stall = 0; flush = 0;
    rs_addr = 0; rt_addr = 0; rd_addr = 0; rs_data = 0; rt_data = 0;
    imm = 0; imm_sext = 0; alu_src = 0; alu_cmd = 0; reg_we = 0;
    exmem_we = 0; exmem_rd = 0; exmem_data = 0;
    memwb_we = 0; memwb_rd = 0; memwb_data = 0;
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] cmd, input logic [4:0] rd,
                         input logic we, input logic [1:0] fa, input logic [1:0] fb);
    chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(v));
    chk({tag, ".operandA"}, operandA, a);
    chk({tag, ".operandB"}, operandB, b);
    chk({tag, ".command"}, 32'(command), 32'(cmd));
    chk({tag, ".ex_rd"}, 32'(ex_rd), 32'(rd));
    chk({tag, ".ex_reg_we"}, 32'(ex_reg_we), 32'(we));
    chk({tag, ".fwd_a"}, 32'(fwd_a), 32'(fa));
    chk({tag, ".fwd_b"}, 32'(fwd_b), 32'(fb));
    $display("step %-10s valid=%0d A=%08h B=%08h cmd=%0d rd=%0d we=%0d fa=%0d fb=%0d stalls=%0d",
             tag, ex_valid, operandA, operandB, command, ex_rd, ex_reg_we, fwd_a, fwd_b, stall_cycles);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset.stalls", 32'(stall_cycles), 0);

    // EX/MEM outranks MEM/WB for rs; rt reads the register file
    @(negedge clk);
    rst_n = 1;
    in_valid = 1; reg_we = 1; rd_addr = 5; alu_cmd = 3'd0;
    rs_addr = 3; rs_data = 5; rt_addr = 4; rt_data = 32'h0000_1234;
    exmem_we = 1; exmem_rd = 3; exmem_data = 9;
    memwb_we = 1; memwb_rd = 3; memwb_data = 7;
    step();
    chk_all("fwd_exmem", 1, 9, 32'h1234, 0, 5, 1, 1, 0);

    // MEM/WB path on both operands
    exmem_we = 0; rt_addr = 3; alu_cmd = 3'd1; rd_addr = 6;
    step();
    chk_all("fwd_memwb", 1, 7, 7, 1, 6, 1, 2, 2);

    // Register 0 is never bypassed
    rs_addr = 0; rs_data = 32'h55; rt_addr = 0; rt_data = 0;
    exmem_we = 1; exmem_rd = 0; exmem_data = 32'hFFFF_FFFF;
    memwb_we = 1; memwb_rd = 0; memwb_data = 32'hAAAA_AAAA;
    alu_cmd = 3'd2; rd_addr = 7;
    step();
    chk_all("reg0", 1, 32'h55, 0, 2, 7, 1, 0, 0);

    // Immediate operand, sign- and zero-extended; rt bypass must be ignored
    exmem_rd = 8; rt_addr = 8; rs_addr = 1; rs_data = 32'h11;
    alu_src = 1; imm = 16'h8000; imm_sext = 1; alu_cmd = 3'd3;
    step();
    chk_all("imm_sext", 1, 32'h11, 32'hFFFF_8000, 3, 7, 1, 0, 0);
    imm_sext = 0;
    step();
    chk_all("imm_zext", 1, 32'h11, 32'h0000_8000, 3, 7, 1, 0, 0);

    // Bubble capture: valid/we cleared, operands still loaded
    in_valid = 0; reg_we = 1; alu_src = 0; exmem_we = 0; memwb_we = 0;
    rs_data = 32'h22; rt_addr = 9; rt_data = 32'h33; rd_addr = 10; alu_cmd = 3'd4;
    step();
    chk_all("bubble", 0, 32'h22, 32'h33, 4, 10, 0, 0, 0);

    // Capture ADD then hold through three stalled cycles with moving inputs
    in_valid = 1; reg_we = 1; rs_addr = 2; rs_data = 32'hA; rt_addr = 4;
    rt_data = 32'hB; rd_addr = 12; alu_cmd = 3'd0;
    step();
    chk_all("capture", 1, 32'hA, 32'hB, 0, 12, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      stall = 1;
      rs_data = 32'h100 + 32'(i); rt_data = 32'h200 + 32'(i); alu_cmd = 3'd7;
      rd_addr = 5'(20 + i); exmem_we = 1; exmem_rd = 2; exmem_data = 32'hDEAD;
      step();
      chk_all("stall", 1, 32'hA, 32'hB, 0, 12, 1, 0, 0);
    end
    chk("stall.count3", 32'(stall_cycles), 3);

    // Stall together with flush: flush wins and the counter stays put
    flush = 1; stall = 1;
    step();
    chk_all("stall_flush", 0, 32'hA, 32'hB, 0, 12, 0, 0, 0);
    chk("stall_flush.count", 32'(stall_cycles), 3);

    // Recapture, then flush alone
    flush = 0; stall = 0; exmem_we = 0; rs_data = 32'h44; rt_data = 32'h66;
    alu_cmd = 3'd6; rd_addr = 13;
    step();
    chk_all("recapture", 1, 32'h44, 32'h66, 6, 13, 1, 0, 0);
    flush = 1; rs_data = 32'h99;
    step();
    chk_all("flush", 0, 32'h44, 32'h66, 0, 13, 0, 0, 0);

    // Asynchronous reset between edges while an instruction is valid
    flush = 0; rs_data = 32'h77; alu_cmd = 3'd5; rd_addr = 14;
    step();
    chk_all("pre_rst", 1, 32'h77, 32'h66, 5, 14, 1, 0, 0);
    #2;
    rst_n = 0; stall = 1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("async_rst.count", 32'(stall_cycles), 0);

    // Release mid-stall: held instruction is gone, stall counts from zero
    @(negedge clk);
    rst_n = 1;
    step();
    chk_all("post_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst.count", 32'(stall_cycles), 1);

    // Counter saturates at all-ones (7 for a 3-bit counter)
    for (int i = 0; i < 8; i++) step();
    chk("saturate", 32'(stall_cycles), 7);
    stall = 0;
    step();
    chk("saturate.hold", 32'(stall_cycles), 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: STALL_CNT_W, 16, width of saturating stall-cycle counter.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  decoded instruction present from ID.
REQ-005 stall  in  1  hold stage contents (hazard unit).
REQ-006 flush  in  1  squash stage contents (branch/jump).
REQ-007 rs_addr, rt_addr, rd_addr  in  5 each  source/destination register numbers.
REQ-008 rs_data, rt_data  in  32 each  register-file read data.
REQ-009 imm  in  16  instruction immediate; imm_sext  in  1  1=sign-extend, 0=zero-extend.
REQ-010 alu_src  in  1  1=operandB from extended imm, 0=from rt path.
REQ-011 alu_cmd  in  3  ALU command (ADD..OR encoding); reg_we  in  1  instruction writes rd.
REQ-012 exmem_we, exmem_rd, exmem_data  in  1/5/32  EX/MEM writeback candidate.
REQ-013 memwb_we, memwb_rd, memwb_data  in  1/5/32  MEM/WB writeback candidate.
REQ-014 ex_valid  out  1  registered instruction valid for EX.
REQ-015 operandA, operandB  out  32 each  registered ALU operands.
REQ-016 command  out  3  registered ALU command.
REQ-017 ex_rd, ex_reg_we  out  5/1  registered destination and write enable (ex_reg_we=0 when ex_valid=0).
REQ-018 fwd_a, fwd_b  out  2 each  registered forwarding source used at capture.
REQ-019 stall_cycles  out  STALL_CNT_W  count of cycles with stall=1 and flush=0.

Function
REQ-020 Latency: one cycle ID→EX; outputs are register outputs only, no combinational input-to-output path.
REQ-021 Priority per edge: flush > stall > capture.
REQ-022 flush=1: ex_valid←0, ex_reg_we←0, command←ADD(0); data registers don't-care but SHALL hold.
REQ-023 stall=1, flush=0: all outputs hold previous values; stall_cycles increments.
REQ-024 Neither: capture in_valid, ex_rd←rd_addr, ex_reg_we←reg_we&in_valid, command←alu_cmd, forwarded operands.
REQ-025 Forward A: exmem_we & exmem_rd==rs_addr & rs_addr!=0 → exmem_data (fwd 1); else memwb_we & memwb_rd==rs_addr & rs_addr!=0 → memwb_data (fwd 2); else rs_data (fwd 0).
REQ-026 Forward B: same rule on rt_addr/rt_data; applies only when alu_src=0.
REQ-027 alu_src=1: operandB←{16{imm[15]&imm_sext},imm}; fwd_b←0.
REQ-028 Register 0 never forwarded even if a writer targets it.
REQ-029 in_valid=0 capture: ex_valid←0, ex_reg_we←0; operands still loaded.
REQ-030 stall_cycles saturates at all-ones; no wrap.
REQ-031 Simultaneous stall+flush: flush wins; counter does not increment.

Reset
REQ-032 rst_n low asynchronously forces ex_valid=0, operandA=0, operandB=0, command=0, ex_rd=0, ex_reg_we=0, fwd_a=0, fwd_b=0, stall_cycles=0.
REQ-033 Reset asserted mid-stall discards held instruction; first edge after release behaves per REQ-021.

Structure
REQ-034 Shared package holds ALU command constants (ADD 0, SUB 1, XOR 2, SLT 3, AND 4, NAND 5, NOR 6, OR 7) and forward-select constants (REG 0, EXMEM 1, MEMWB 2).
REQ-035 One sub-module, fwd_select (addr, reg data, both writeback candidates → data, select), instantiated twice.

Verification
REQ-036 rs=3,rs_data=5, exmem_we=1,exmem_rd=3,exmem_data=9, memwb_rd=3,memwb_data=7 → operandA=9, fwd_a=1 next cycle.
REQ-037 rt=0, exmem_we=1, exmem_rd=0, exmem_data=0xFFFF_FFFF, rt_data=0 → operandB=0, fwd_b=0.
REQ-038 alu_src=1, imm=0x8000: imm_sext=1 → operandB=0xFFFF_8000; imm_sext=0 → 0x0000_8000.
REQ-039 Capture ADD, then stall 3 cycles with changing inputs → outputs unchanged, stall_cycles=3.
REQ-040 stall=1 and flush=1 same edge → ex_valid=0, ex_reg_we=0, stall_cycles unchanged.
REQ-041 Drop rst_n between edges while ex_valid=1 → all outputs 0 immediately, no clock edge required.
